// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a W-bit pattern on start and shifts it out
// MSB-first for repeat_n+1 frames, with an optional idle gap between frames.
module seq_pattern_tx #(
    parameter int unsigned W  = 8,
    parameter int unsigned RW = 4,
    parameter int unsigned GW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [RW-1:0] repeat_n,
    input  logic [GW-1:0] gap,
    output logic          out,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [1:0]    cs
);

    localparam int unsigned BCW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BCW-1:0] BC_LAST = BCW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        cs_q, cs_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic [RW-1:0] fc_q, fc_d;
    logic [GW-1:0] gap_l_q, gap_l_d;
    logic [GW-1:0] gc_q, gc_d;
    logic          out_q, out_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state logic; outputs are pre-decoded from the next state so they leave a flop.
    always_comb begin
        cs_d    = cs_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        bc_d    = bc_q;
        fc_d    = fc_q;
        gap_l_d = gap_l_q;
        gc_d    = gc_q;

        case (cs_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    sh_d    = pattern;
                    fc_d    = repeat_n;
                    gap_l_d = gap;
                    bc_d    = BC_LAST;
                    cs_d    = SEND;
                end
            end
            SEND: begin
                sh_d = {sh_q[W-2:0], 1'b0};
                bc_d = bc_q - BCW'(1);
                if (bc_q == '0) begin
                    if (fc_q == '0) begin
                        cs_d = DONE;
                    end else begin
                        fc_d = fc_q - RW'(1);
                        if (gap_l_q == '0) begin
                            // Back-to-back frames: reload without a bubble.
                            sh_d = pat_q;
                            bc_d = BC_LAST;
                        end else begin
                            gc_d = gap_l_q - GW'(1);
                            cs_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gc_q == '0) begin
                    sh_d = pat_q;
                    bc_d = BC_LAST;
                    cs_d = SEND;
                end else begin
                    gc_d = gc_q - GW'(1);
                end
            end
            DONE: begin
                cs_d = IDLE;
            end
            default: begin
                cs_d = IDLE;
            end
        endcase

        out_d   = (cs_d == SEND) & sh_d[W-1];
        valid_d = (cs_d == SEND);
        busy_d  = (cs_d == SEND) | (cs_d == GAP);
        done_d  = (cs_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q    <= IDLE;
            sh_q    <= '0;
            pat_q   <= '0;
            bc_q    <= '0;
            fc_q    <= '0;
            gap_l_q <= '0;
            gc_q    <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cs_q    <= cs_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            bc_q    <= bc_d;
            fc_q    <= fc_d;
            gap_l_q <= gap_l_d;
            gc_q    <= gc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign cs    = cs_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a cycle-level expected-output queue built from the
// transaction parameters is compared against the DUT every cycle.
module tb_seq_pattern_tx;

    localparam int W  = 8;
    localparam int RW = 4;
    localparam int GW = 4;

    typedef struct packed {
        logic       out;
        logic       valid;
        logic       busy;
        logic       done;
        logic [1:0] cs;
    } exp_t;

    localparam exp_t IDLE_E = '{out: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, cs: 2'd0};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  pattern;
    logic [RW-1:0] repeat_n;
    logic [GW-1:0] gap;
    logic          out, valid, busy, done;
    logic [1:0]    cs;

    exp_t q[$];
    exp_t cur = IDLE_E;
    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_cnt = 0;
    int   hits = 0;
    logic [7:0] win = 8'h00;

    seq_pattern_tx #(.W(W), .RW(RW), .GW(GW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .gap      (gap),
        .out      (out),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .cs       (cs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected cycles of a whole transaction: frames of W bits, gaps between, one DONE.
    task automatic push_tx(input logic [W-1:0] p, input int r, input int g);
        for (int f = 0; f <= r; f++) begin
            for (int i = 0; i < W; i++)
                q.push_back('{out: p[W-1-i], valid: 1'b1, busy: 1'b1, done: 1'b0, cs: 2'd1});
            if (f < r)
                for (int k = 0; k < g; k++)
                    q.push_back('{out: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0, cs: 2'd2});
        end
        q.push_back('{out: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b1, cs: 2'd3});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            q.delete();
            cur = IDLE_E;
        end else begin
            if (cur.cs == 2'd0 && start)
                push_tx(pattern, int'(repeat_n), int'(gap));
            if (q.size() > 0) cur = q.pop_front();
            else cur = IDLE_E;
        end
        @(negedge clk);
        check("cycle{out,valid,busy,done,cs}", 32'({out, valid, busy, done, cs}), 32'(cur));
        if (busy) busy_cnt++;
        if (valid) begin
            win = {win[6:0], out};
            if (win == 8'hAB) hits++;
        end
    endtask

    task automatic run_tx(input logic [W-1:0] p, input logic [RW-1:0] r, input logic [GW-1:0] g);
        pattern  = p;
        repeat_n = r;
        gap      = g;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2000 && cur.cs != 2'd0; i++) tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; pattern = 8'hAB; repeat_n = '0; gap = '0;
        tick();
        tick();
        start = 1'b0;
        check("reset_cs", 32'(cs), 32'd0);
        rst = 1'b0;
        tick();

        // Single frame with an in-bench AB detector on the serial stream.
        win = 8'h00; hits = 0;
        run_tx(8'hAB, 4'd0, 4'd0);
        check("single_detect_hits", 32'(hits), 32'd1);

        busy_cnt = 0;
        run_tx(8'hAB, 4'd2, 4'd0);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'd24);

        busy_cnt = 0;
        run_tx(8'hC3, 4'd1, 4'd3);
        check("gapped_busy_cycles", 32'(busy_cnt), 32'd19);

        // start held through SEND/DONE with changing inputs; re-accepted in first IDLE.
        pattern = 8'hAB; repeat_n = 4'd1; gap = 4'd2; start = 1'b1;
        tick();
        for (int i = 0; i < 2000 && cur.cs != 2'd3; i++) begin
            pattern = 8'h5A; repeat_n = '0; gap = '0;
            tick();
        end
        tick();
        check("restart_idle_cs", 32'(cs), 32'd0);
        tick();
        start = 1'b0;
        check("restart_send_cs", 32'(cs), 32'd1);
        for (int i = 0; i < 2000 && cur.cs != 2'd0; i++) tick();
        tick();

        // Reset on frame 2, bit 4.
        pattern = 8'hAB; repeat_n = 4'd2; gap = '0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        run_tx(8'h96, 4'd0, 4'd1);

        busy_cnt = 0;
        run_tx(8'hAB, 4'd3, 4'd15);
        check("edge_busy_77", 32'(busy_cnt), 32'd77);

        busy_cnt = 0;
        run_tx(8'h81, 4'd15, 4'd0);
        check("max_repeat_busy", 32'(busy_cnt), 32'd128);

        // Randomized transactions with noisy inputs and occasional reset.
        for (int n = 0; n < 25; n++) begin
            pattern  = W'($urandom);
            repeat_n = ($urandom_range(0, 4) == 0) ? RW'($urandom) : RW'($urandom_range(0, 3));
            gap      = GW'($urandom);
            start    = 1'b1;
            tick();
            for (int i = 0; i < 3000 && cur.cs != 2'd0; i++) begin
                start    = ($urandom_range(0, 3) == 0);
                pattern  = W'($urandom);
                repeat_n = RW'($urandom);
                gap      = GW'($urandom);
                rst      = ($urandom_range(0, 299) == 0);
                tick();
                rst = 1'b0;
            end
            start = 1'b0;
            tick();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
